// File: rtl/sim_ctrl_pkg.sv
// Shared types and default constants for the simulation run controller.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NCH_DEF        = 2;
  localparam int CODE_W_DEF     = 32;
  localparam int CNT_W_DEF      = 64;
  localparam int RST_CYCLES_DEF = 13;

  // Channel index width; a single channel still needs one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with a request-present flag.
module prio_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Sequences DUT reset, counts run cycles and captures the first exit request
// or cycle-limit timeout; results stay frozen until the next reset.
//
// state | meaning
// HOLD  | DUT reset asserted for RST_CYCLES cycles, limit latched on exit
// RUN   | counting cycles, watching exit requests and the cycle limit
// DONE  | run finished, all outputs frozen until rst
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int CODE_W     = CODE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        max_cycle,
  input  logic [NCH-1:0]          exit_valid,
  input  logic [NCH*CODE_W-1:0]   exit_code,
  output logic                    rst_out,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    done,
  output logic                    fail,
  output logic                    timeout,
  output logic [chan_w(NCH)-1:0]  done_chan,
  output logic [CODE_W-1:0]       done_code
);

  localparam int CH_W   = chan_w(NCH);
  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               rst_out_q, rst_out_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [CH_W-1:0]    done_chan_q, done_chan_d;
  logic [CODE_W-1:0]  done_code_q, done_code_d;

  logic [CH_W-1:0]    win_idx;
  logic               win_valid;
  logic [CODE_W-1:0]  win_code;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hold_done;
  logic               exit_hit;
  logic               limit_hit;

  prio_enc #(.N(NCH), .W(CH_W)) u_prio_enc (
    .req   (exit_valid),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_code  = exit_code[win_idx*CODE_W +: CODE_W];
  assign cnt_inc   = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  assign hold_done = (hold_cnt_q == HOLD_W'(RST_CYCLES - 1));
  assign exit_hit  = (state_q == RUN) && win_valid;
  // Compare against the post-increment value: timeout lands on the edge the count reaches the limit.
  assign limit_hit = (state_q == RUN) && (limit_q != '0) && (cnt_inc == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HOLD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (hold_done) state_d = RUN;
      RUN:     if (exit_hit || limit_hit) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    limit_d     = limit_q;
    cycle_cnt_d = cycle_cnt_q;
    rst_out_d   = rst_out_q;
    done_d      = done_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    done_chan_d = done_chan_q;
    done_code_d = done_code_q;
    case (state_q)
      HOLD: begin
        rst_out_d  = 1'b1;
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_done) begin
          rst_out_d = 1'b0;
          limit_d   = max_cycle;
        end
      end
      RUN: begin
        rst_out_d   = 1'b0;
        cycle_cnt_d = cnt_inc;
        if (exit_hit) begin
          done_d      = 1'b1;
          done_chan_d = win_idx;
          done_code_d = win_code;
          fail_d      = |win_code;
          timeout_d   = 1'b0;
        end else if (limit_hit) begin
          done_d      = 1'b1;
          done_chan_d = '0;
          done_code_d = '0;
          fail_d      = 1'b1;
          timeout_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      limit_q     <= '0;
      cycle_cnt_q <= '0;
      rst_out_q   <= 1'b1;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_chan_q <= '0;
      done_code_q <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      limit_q     <= limit_d;
      cycle_cnt_q <= cycle_cnt_d;
      rst_out_q   <= rst_out_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      done_chan_q <= done_chan_d;
      done_code_q <= done_code_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign done_chan = done_chan_q;
  assign done_code = done_code_q;

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of exit-report channels (1..16).
REQ-002 SHALL have parameter CODE_W, default 32, exit-code width.
REQ-003 SHALL have parameter CNT_W, default 64, cycle-counter width.
REQ-004 SHALL have parameter RST_CYCLES, default 13, cycles the DUT reset is held after rst deasserts (minimum 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port max_cycle, input, CNT_W, run-cycle limit; 0 means unlimited.
REQ-008 SHALL have port exit_valid, input, NCH, per-channel exit request.
REQ-009 SHALL have port exit_code, input, NCH*CODE_W, per-channel code; channel i occupies [i*CODE_W +: CODE_W].
REQ-010 SHALL have port rst_out, output, 1, active-high DUT reset.
REQ-011 SHALL have port cycle_cnt, output, CNT_W, run cycles elapsed.
REQ-012 SHALL have port done, output, 1, run finished (sticky).
REQ-013 SHALL have port fail, output, 1, finished with nonzero code or by timeout.
REQ-014 SHALL have port timeout, output, 1, finished by cycle limit.
REQ-015 SHALL have port done_chan, output, $clog2(NCH) (min 1), channel that ended the run.
REQ-016 SHALL have port done_code, output, CODE_W, captured exit code.

Function
REQ-017 SHALL implement FSM states HOLD, RUN, DONE; all outputs registered.
REQ-018 HOLD: rst_out=1, hold counter counts up to RST_CYCLES; on the edge completing RST_CYCLES cycles, go to RUN, deassert rst_out, and latch max_cycle into an internal limit register.
REQ-019 Changes to max_cycle after leaving HOLD SHALL be ignored.
REQ-020 exit_valid SHALL be ignored in HOLD and DONE.
REQ-021 RUN: cycle_cnt SHALL increment by 1 every cycle, saturating at all-ones with no wrap.
REQ-022 RUN with any exit_valid bit set: the lowest-index set channel SHALL win. On that edge:
  - go to DONE
  - done=1
  - done_chan = winning index, done_code = its code
  - fail = (code != 0), timeout = 0
  - cycle_cnt still increments on that edge
REQ-023 RUN with limit != 0, on the edge where cycle_cnt becomes equal to the limit: go to DONE with done=1, timeout=1, fail=1, done_code=0, done_chan=0.
REQ-024 An exit on the same edge as the timeout SHALL take priority; timeout stays 0.
REQ-025 Limit = 0 SHALL never time out; cycle_cnt saturates.
REQ-026 DONE SHALL be sticky: all outputs frozen, rst_out=0, until rst.
REQ-027 rst asserted in any state (including mid-RUN) SHALL return to HOLD immediately (asynchronously) with all outputs at reset values.

Reset
REQ-028 Reset values:
  - state=HOLD, rst_out=1
  - hold counter=0, cycle_cnt=0, limit=0
  - done=0, fail=0, timeout=0, done_chan=0, done_code=0
REQ-029 rst_out SHALL be 1 combinationally-free from the first cycle of rst assertion, driven from an async-set flop.

Structure
REQ-030 Package sim_ctrl_pkg SHALL hold the state enum (HOLD/RUN/DONE) and the default parameter constants.
REQ-031 A single sub-module prio_enc (NCH-input lowest-index priority encoder with a valid output) SHALL compute the winning channel.

Verification
REQ-032 NCH=2, RST_CYCLES=13, max_cycle=0: release rst -> rst_out=1 for exactly 13 edges then 0; cycle_cnt=0 at the first RUN cycle.
REQ-033 In RUN, pulse exit_valid=2'b10 with ch1 code 0 at cycle_cnt=5 -> done=1, fail=0, done_chan=1, done_code=0, cycle_cnt=6, frozen thereafter.
REQ-034 exit_valid=2'b11 with ch0 code 3 and ch1 code 0 -> done_chan=0, done_code=3, fail=1.
REQ-035 max_cycle=100, no exit -> done=timeout=fail=1 with cycle_cnt=100; max_cycle changed to 50 during RUN has no effect.
REQ-036 max_cycle=10 with exit on ch0 (code 0) in the same cycle cycle_cnt becomes 10 -> timeout=0, fail=0.
REQ-037 Assert rst at cycle_cnt=40, then release -> rst_out=1 immediately, outputs at reset values, full 13-cycle HOLD repeats.
